// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
//
// The operation moves through four stages: ALIGN, ADD, NORM and DONE.
// Rounding is truncation, and denormal inputs are treated as zero.
//
// Ports:
//   clk       - system clock; all state changes on the rising edge
//   rst_n     - asynchronous active-low reset
//   start     - request a new operation; sampled only while idle
//   op        - 0: a + b, 1: a - b
//   a, b      - IEEE-754 single operands, latched when start is accepted
//   result    - registered result; holds until the next operation completes
//   done      - one-cycle pulse while result is freshly valid
//   busy      - high whenever an operation is in flight (state not IDLE)
//   overflow  - result exponent saturated to infinity
//   underflow - nonzero result flushed to zero
//   invalid   - an operand had exponent 255; result is the default quiet NaN
module fp_addsub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + 5'd1;
                end
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    state_t      state_r, state_next_s;
    logic [31:0] a_r, b_r;
    logic        op_r;
    logic [23:0] big_sig_r, small_sig_r;
    logic [7:0]  exp_r;
    logic        sign_r, eff_sub_r, inv_r;
    logic [24:0] sum_r;
    logic [31:0] result_r;
    logic        done_r, busy_r, overflow_r, underflow_r, invalid_r;

    logic [7:0]  exp_a_s, exp_b_s, exp_big_s, exp_small_s, diff_s;
    logic [23:0] sig_a_s, sig_b_s, sig_big_s, sig_small_s, shifted_s;
    logic        sign_b_s, a_big_s, sign_big_s, invalid_in_s;

    logic [4:0]  lz_s;
    logic [23:0] norm_s;
    logic [22:0] frac_s;
    logic [9:0]  exp_n_s;
    logic [31:0] res_s;
    logic        ovf_s, udf_s, inv_s;

    // Next-state logic for the operation sequencer
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_next_s = ST_ADD;
            ST_ADD:   state_next_s = ST_NORM;
            ST_NORM:  state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Operand unpack, magnitude ordering and alignment shift
    always_comb begin
        exp_a_s  = a_r[30:23];
        exp_b_s  = b_r[30:23];
        sig_a_s  = (exp_a_s == 8'd0) ? 24'd0 : {1'b1, a_r[22:0]};
        sig_b_s  = (exp_b_s == 8'd0) ? 24'd0 : {1'b1, b_r[22:0]};
        sign_b_s = b_r[31] ^ op_r;
        a_big_s  = (exp_a_s > exp_b_s) || ((exp_a_s == exp_b_s) && (sig_a_s >= sig_b_s));
        if (a_big_s) begin
            exp_big_s   = exp_a_s;
            exp_small_s = exp_b_s;
            sig_big_s   = sig_a_s;
            sig_small_s = sig_b_s;
            sign_big_s  = a_r[31];
        end else begin
            exp_big_s   = exp_b_s;
            exp_small_s = exp_a_s;
            sig_big_s   = sig_b_s;
            sig_small_s = sig_a_s;
            sign_big_s  = sign_b_s;
        end
        diff_s = exp_big_s - exp_small_s;
        if (diff_s >= 8'd25) begin
            shifted_s = 24'd0;
        end else begin
            shifted_s = sig_small_s >> diff_s;
        end
        invalid_in_s = (exp_a_s == 8'hFF) || (exp_b_s == 8'hFF);
    end

    // Normalisation, exponent range checks and result packing
    always_comb begin
        lz_s    = lzc24(sum_r[23:0]);
        norm_s  = 24'd0;
        frac_s  = 23'd0;
        exp_n_s = 10'd0;
        res_s   = 32'd0;
        ovf_s   = 1'b0;
        udf_s   = 1'b0;
        inv_s   = 1'b0;
        if (inv_r) begin
            res_s = 32'h7FC0_0000;
            inv_s = 1'b1;
        end else if (sum_r == 25'd0) begin
            res_s = 32'd0;
        end else begin
            if (sum_r[24]) begin
                frac_s  = sum_r[23:1];
                exp_n_s = {2'b00, exp_r} + 10'd1;
            end else begin
                norm_s  = sum_r[23:0] << lz_s;
                frac_s  = norm_s[22:0];
                exp_n_s = {2'b00, exp_r} - {5'd0, lz_s};
            end
            if ($signed(exp_n_s) >= $signed(10'd255)) begin
                res_s = {sign_r, 8'hFF, 23'd0};
                ovf_s = 1'b1;
            end else if ($signed(exp_n_s) <= $signed(10'd0)) begin
                res_s = {sign_r, 31'd0};
                udf_s = 1'b1;
            end else begin
                res_s = {sign_r, exp_n_s[7:0], frac_s};
            end
        end
    end

    // Sequencer state, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            op_r        <= 1'b0;
            big_sig_r   <= 24'd0;
            small_sig_r <= 24'd0;
            exp_r       <= 8'd0;
            sign_r      <= 1'b0;
            eff_sub_r   <= 1'b0;
            inv_r       <= 1'b0;
            sum_r       <= 25'd0;
            result_r    <= 32'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            invalid_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                    end
                end
                ST_ALIGN: begin
                    big_sig_r   <= sig_big_s;
                    small_sig_r <= shifted_s;
                    exp_r       <= exp_big_s;
                    sign_r      <= sign_big_s;
                    eff_sub_r   <= a_r[31] ^ sign_b_s;
                    inv_r       <= invalid_in_s;
                end
                ST_ADD: begin
                    if (eff_sub_r) begin
                        sum_r <= {1'b0, big_sig_r} - {1'b0, small_sig_r};
                    end else begin
                        sum_r <= {1'b0, big_sig_r} + {1'b0, small_sig_r};
                    end
                end
                ST_NORM: begin
                    result_r    <= res_s;
                    overflow_r  <= ovf_s;
                    underflow_r <= udf_s;
                    invalid_r   <= inv_s;
                end
                ST_DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign result    = result_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign invalid   = invalid_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Randomised self-checking bench for fp_addsub_seq against a numeric model.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        done, busy, overflow, underflow, invalid;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_res = 32'd0;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Model: {overflow, underflow, invalid, result}
  function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic o);
    int ex, ey, mx, my, eb, es, mb, ms, d, s, e;
    bit sx, sy, sgn;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 255 || ey == 255) return {3'b001, 32'h7FC0_0000};
    mx = (ex == 0) ? 0 : (int'(x[22:0]) + (1 << 23));
    my = (ey == 0) ? 0 : (int'(y[22:0]) + (1 << 23));
    sx = x[31];
    sy = y[31] ^ o;
    if (ex > ey || (ex == ey && mx >= my)) begin
      eb = ex; mb = mx; es = ey; ms = my; sgn = sx;
    end else begin
      eb = ey; mb = my; es = ex; ms = mx; sgn = sy;
    end
    d = eb - es;
    ms = (d >= 25) ? 0 : (ms >> d);
    s = (sx != sy) ? (mb - ms) : (mb + ms);
    if (s == 0) return 35'd0;
    e = eb;
    while (s >= (1 << 24)) begin s = s >> 1; e++; end
    while (s < (1 << 23)) begin s = s << 1; e--; end
    if (e >= 255) return {3'b100, sgn, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b010, sgn, 31'd0};
    return {3'b000, sgn, e[7:0], s[22:0]};
  endfunction

  // One full operation; inputs are scrambled right after acceptance
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
    logic [34:0] m;
    m = ref_model(ta, tb_v, top);
    @(negedge clk);
    a = ta; b = tb_v; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    check("busy_align", {31'd0, busy}, 32'd1);
    check("done_align", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done_add", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done_norm", {31'd0, done}, 32'd0);
    check("hold_norm", result, prev_res);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("result", result, m[31:0]);
    check("flags", {29'd0, overflow, underflow, invalid}, {29'd0, m[34:32]});
    @(negedge clk);
    check("done_clear", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    prev_res = m[31:0];
  endtask

  function automatic logic [31:0] rnd_fp(input int lo, input int hi);
    logic [7:0] e;
    e = 8'($urandom_range(lo, hi));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] x, y;
    logic [34:0] m;
    int mode, ex;

    #2;
    check("rst_result", result, 32'd0);
    check("rst_status", {27'd0, done, busy, overflow, underflow, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b1);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
    run_op(32'h7F80_0000, 32'h1234_5678, 1'b0);
    run_op(32'h3FC0_0000, 32'h3080_0000, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0040_0000, 32'hC000_0000, 1'b0);
    run_op(32'h0080_0001, 32'h0080_0000, 1'b1);

    // Start re-asserted with new operands while busy is ignored
    m = ref_model(32'h4000_0000, 32'h3F80_0000, 1'b0);
    @(negedge clk);
    a = 32'h4000_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      check("ign_done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
    end
    start = 1'b0;
    check("ign_result", result, m[31:0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_no_queue", {30'd0, done, busy}, 32'd0);
    end
    prev_res = m[31:0];

    // Reset pulsed during ADD aborts the operation
    @(negedge clk);
    a = 32'h4100_0000; b = 32'h3F80_0000; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_status", {27'd0, done, busy, overflow, underflow, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", {30'd0, done, busy}, 32'd0);
    end
    prev_res = 32'd0;
    run_op(32'h3F80_0000, 32'h4000_0000, 1'b0);

    // Randomised operations biased toward interesting exponent ranges
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin x = $urandom; y = $urandom; end
        1: begin
          x = rnd_fp(1, 254);
          ex = int'(x[30:23]);
          y = rnd_fp((ex > 3) ? ex - 3 : 1, (ex < 251) ? ex + 3 : 254);
        end
        2: begin x = rnd_fp(0, 4); y = rnd_fp(0, 4); end
        3: begin x = rnd_fp(250, 255); y = rnd_fp(250, 255); end
        default: begin
          x = rnd_fp(1, 254);
          y = {1'($urandom_range(0, 1)), x[30:0]};
          if ($urandom_range(0, 1) == 1) y[0] = ~y[0];
        end
      endcase
      run_op(x, y, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
